// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU memory
// controller (master) and the unified memory responder (slave).
//   req    - access request, sampled by the slave only while idle
//   we     - 1 = write, 0 = read, sampled with req
//   addr   - byte address, sampled with req
//   wdata  - write data, sampled with req
//   rdata  - registered read data, held until the next completed read
//   ready  - one-cycle pulse marking access completion
//   busy   - slave is processing an access
//   err    - misaligned-access flag, meaningful only with ready
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory slave for the multicycle
// CPU. Accepts one word access at a time, waits WAIT wait states, then
// performs the access and pulses ready for one cycle.
//
// Parameters:
//   DEPTH - memory size in 32-bit words (power of two, >= 4)
//   WAIT  - wait states per access (0..15)
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset (control and rdata only;
//           the memory array is never reset)
//   bus   - mem_responder_if.slave (req/we/addr/wdata in,
//           rdata/ready/busy/err out)
// Build option:
//   MEM_ALIGN_CHK_EN - when defined, a request with addr[1:0] != 0 raises
//   err in its ready cycle, a misaligned write is dropped and a misaligned
//   read returns zero. When undefined, addr[1:0] is ignored and err is 0.
module mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic          req_we_p0;
  logic [AW-1:0] req_idx_p0;
  logic [31:0]   req_wdata_p0;
  logic          req_mis_p0;

  logic [31:0] mem [DEPTH];

  logic          in_mis;
  logic          accept;
  logic          acc_fire;
  logic          acc_we;
  logic          acc_mis;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;

  // Address bits above the word index alias; the low two bits are only
  // looked at when the alignment check is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef MEM_ALIGN_CHK_EN
  assign in_mis = (bus.addr[1:0] != 2'b00);
`else
  assign in_mis = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && bus.req;

  // With zero wait states the access happens on the accepting edge, so it
  // must use the live bus inputs; otherwise it uses the latched request.
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = 1'b0;
    acc_mis   = 1'b0;
    acc_idx   = '0;
    acc_wdata = '0;
    if (WAIT == 0) begin
      acc_fire  = accept;
      acc_we    = bus.we;
      acc_mis   = in_mis;
      acc_idx   = bus.addr[AW+1:2];
      acc_wdata = bus.wdata;
    end else begin
      acc_fire  = (state == ST_WAIT) && (cnt == 4'd0);
      acc_we    = req_we_p0;
      acc_mis   = req_mis_p0;
      acc_idx   = req_idx_p0;
      acc_wdata = req_wdata_p0;
    end
  end

  // ---- p0: request capture at acceptance ----
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_p0    <= bus.we;
      req_idx_p0   <= bus.addr[AW+1:2];
      req_wdata_p0 <= bus.wdata;
      req_mis_p0   <= in_mis;
    end
  end

  // ---- access: memory commit ----
  // Gated by reset so a write caught mid-access by reset is discarded.
  always_ff @(posedge clk) begin
    if (!reset && acc_fire && acc_we && !acc_mis) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      bus.ready <= 1'b0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            bus.busy <= 1'b1;
            if (WAIT == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase

      if (acc_fire) begin
        bus.ready <= 1'b1;
        bus.err   <= acc_mis;
        if (!acc_we) begin
          bus.rdata <= acc_mis ? 32'd0 : mem[acc_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. Drives a WAIT=2
// instance through directed and randomized accesses checked against an
// array model, and a WAIT=0 instance with a continuously held request.
module tb_mem_responder;
  localparam int DEPTH  = 64;
  localparam int WAIT_A = 2;
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bA ();
  mem_responder_if b0 ();

  mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bA.slave)
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  logic [31:0] last_rd;
  bit          last_rd_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on the WAIT=2 instance, checked against the model.
  task automatic access_a(input bit w, input logic [31:0] a, input logic [31:0] d);
    int lat;
    int idx;
    bit mis;
    idx = int'((a / 4) % DEPTH);
    mis = ALIGN_EN && ((a % 4) != 0);
    @(negedge clk);
    bA.req   = 1'b1;
    bA.we    = w;
    bA.addr  = a;
    bA.wdata = d;
    @(negedge clk);
    // Scramble inputs after acceptance; the access must use the latched copy.
    bA.req   = 1'b0;
    bA.we    = 1'($urandom);
    bA.addr  = $urandom;
    bA.wdata = $urandom;
    lat = 1;
    while (bA.ready !== 1'b1 && lat < 20) begin
      chk("busy_in_access", 32'(bA.busy), 32'd1);
      chk("err_outside_ready", 32'(bA.err), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("ready_latency", 32'(lat), 32'(WAIT_A + 1));
    chk("err_flag", 32'(bA.err), 32'(mis));
    if (!w) begin
      if (mis) begin
        last_rd = 32'd0;
        last_rd_vld = 1'b1;
      end else if (model_vld[idx]) begin
        last_rd = model_mem[idx];
        last_rd_vld = 1'b1;
      end else begin
        last_rd_vld = 1'b0;
      end
      if (last_rd_vld) chk("read_data", bA.rdata, last_rd);
    end else begin
      if (!mis) begin
        model_mem[idx] = d;
        model_vld[idx] = 1'b1;
      end
      if (last_rd_vld) chk("rdata_hold_on_write", bA.rdata, last_rd);
    end
    @(negedge clk);
    chk("ready_pulse_width", 32'(bA.ready), 32'd0);
    chk("busy_after_resp", 32'(bA.busy), 32'd0);
    if (last_rd_vld) chk("rdata_stable", bA.rdata, last_rd);
  endtask

  // WAIT=0 instance with req held high, alternating addresses 0x0 / 0x4.
  task automatic run_wait0(input bit w, input logic [31:0] d0, input logic [31:0] d1, input int n);
    @(negedge clk);
    b0.req   = 1'b1;
    b0.we    = w;
    b0.addr  = 32'h0;
    b0.wdata = d0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("w0_ready_on", 32'(b0.ready), 32'd1);
      if (!w) chk("w0_rdata", b0.rdata, (k % 2 == 0) ? 32'h11111111 : 32'h22222222);
      b0.addr  = (k % 2 == 0) ? 32'h4 : 32'h0;
      b0.wdata = (k % 2 == 0) ? d1 : d0;
      @(negedge clk);
      chk("w0_ready_off", 32'(b0.ready), 32'd0);
    end
    b0.req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] offs;
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
    bA.req = 1'b0; bA.we = 1'b0; bA.addr = '0; bA.wdata = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_rd = 32'd0;
    last_rd_vld = 1'b1;

    // Reset state and idle behaviour
    chk("rst_ready", 32'(bA.ready), 32'd0);
    chk("rst_err", 32'(bA.err), 32'd0);
    chk("rst_rdata", bA.rdata, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bA.busy), 32'd0);
      chk("idle_ready", 32'(bA.ready), 32'd0);
    end

    // Write then read back
    access_a(1'b1, 32'h10, 32'hDEADBEEF);
    access_a(1'b0, 32'h10, 32'h0);
    chk("deadbeef_read", bA.rdata, 32'hDEADBEEF);

    // Aliasing modulo DEPTH*4 bytes
    access_a(1'b1, 32'h100, 32'hA5A5A5A5);
    access_a(1'b0, 32'h000, 32'h0);
    chk("alias_read", bA.rdata, 32'hA5A5A5A5);

    // Misaligned write then aligned read of the same word
    access_a(1'b1, 32'h20, 32'h55AA00FF);
    access_a(1'b1, 32'h22, 32'h0BADCAFE);
    access_a(1'b0, 32'h20, 32'h0);
    chk("misalign_read", bA.rdata, ALIGN_EN ? 32'h55AA00FF : 32'h0BADCAFE);

    // Reset during the wait states of a write
    access_a(1'b1, 32'h8, 32'hCAFEF00D);
    @(negedge clk);
    bA.req = 1'b1; bA.we = 1'b1; bA.addr = 32'h8; bA.wdata = 32'h12345678;
    @(negedge clk);
    bA.req = 1'b0;
    chk("pre_reset_busy", 32'(bA.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bA.busy), 32'd0);
    chk("midrst_rdata", bA.rdata, 32'd0);
    chk("midrst_err", 32'(bA.err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_ready", 32'(bA.ready), 32'd0);
    end
    reset = 1'b0;
    last_rd = 32'd0;
    last_rd_vld = 1'b1;
    @(negedge clk);
    chk("postrst_no_ready", 32'(bA.ready), 32'd0);
    access_a(1'b0, 32'h8, 32'h0);
    chk("discarded_write", bA.rdata, 32'hCAFEF00D);

    // WAIT=0 with held request
    run_wait0(1'b1, 32'h11111111, 32'h22222222, 2);
    run_wait0(1'b0, 32'h0, 32'h0, 6);

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      offs = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
      a = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8)
          | ($urandom & 32'hFFFF_0000) | offs;
      access_a(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
